// File: rtl/traffic_pkg.sv
// Shared types for the two-road intersection controller: phase encoding and lamp sets.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_ARM      = 3'd0,
    ST_MG_SR    = 3'd1,
    ST_MY_SR    = 3'd2,
    ST_ARS      = 3'd3,
    ST_MR_SG    = 3'd4,
    ST_MR_SY    = 3'd5,
    ST_PED_WALK = 3'd6,
    ST_FLASH    = 3'd7
  } phase_e;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  typedef struct packed {
    lamp_t main_l;
    lamp_t side_l;
    logic  walk;
  } lamp_set_t;

  localparam lamp_t LAMP_R   = 3'b100;
  localparam lamp_t LAMP_Y   = 3'b010;
  localparam lamp_t LAMP_G   = 3'b001;
  localparam lamp_t LAMP_OFF = 3'b000;

  // Lamp pattern for a phase; blink only matters in FLASH.
  function automatic lamp_set_t decode_lamps(input phase_e st, input logic blink);
    lamp_set_t l;
    l = '0;
    case (st)
      ST_MG_SR:    begin l.main_l = LAMP_G; l.side_l = LAMP_R; end
      ST_MY_SR:    begin l.main_l = LAMP_Y; l.side_l = LAMP_R; end
      ST_MR_SG:    begin l.main_l = LAMP_R; l.side_l = LAMP_G; end
      ST_MR_SY:    begin l.main_l = LAMP_R; l.side_l = LAMP_Y; end
      ST_PED_WALK: begin l.main_l = LAMP_R; l.side_l = LAMP_R; l.walk = 1'b1; end
      ST_FLASH:    begin
        l.main_l = blink ? LAMP_Y : LAMP_OFF;
        l.side_l = blink ? LAMP_Y : LAMP_OFF;
      end
      default:     begin l.main_l = LAMP_R; l.side_l = LAMP_R; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick every CLK_DIV cycles.
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] r_cnt;

  assign o_tick_c = (r_cnt == PW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase controller with all-red clearance and flash mode.
// Pedestrian walk phase is built only when TRAFFIC_PED_EN is defined.
module traffic_phase_ctrl #(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned T_GREEN  = 1500,
  parameter int unsigned T_YELLOW = 500,
  parameter int unsigned T_ALLRED = 100,
  parameter int unsigned T_WALK   = 1000,
  parameter int unsigned T_BLINK  = 250,
  parameter int unsigned CNT_W    = 13
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       flash_req,
  input  logic       ped_req,
  output logic       main_R,
  output logic       main_G,
  output logic       main_Y,
  output logic       side_R,
  output logic       side_G,
  output logic       side_Y,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  import traffic_pkg::*;

`ifdef TRAFFIC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  phase_e           r_state, w_state_nx;
  logic [CNT_W-1:0] r_timer, w_timer_nx, w_last;
  logic             r_blink, w_blink_nx;
  logic             r_ped_pending, w_ped_nx;
  logic             w_tick, w_chg, w_ped_grant;
  lamp_set_t        w_lamps;

  // Prescaler restarts with every phase so each phase is exactly T*CLK_DIV cycles.
  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_presc (
    .i_clk    (clk_50),
    .i_rst_n  (reset_n),
    .i_clr    (w_chg),
    .o_tick_c (w_tick)
  );

  always_comb begin
    w_last = CNT_W'(T_ALLRED - 1);
    case (r_state)
      ST_MG_SR, ST_MR_SG: w_last = CNT_W'(T_GREEN - 1);
      ST_MY_SR, ST_MR_SY: w_last = CNT_W'(T_YELLOW - 1);
      ST_PED_WALK:        w_last = CNT_W'(T_WALK - 1);
      ST_FLASH:           w_last = CNT_W'(T_BLINK - 1);
      default:            w_last = CNT_W'(T_ALLRED - 1);
    endcase
  end

  assign w_ped_grant = PED_EN & r_ped_pending;

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_blink_nx = r_blink;
    if (w_tick) begin
      if (r_timer == w_last) begin
        w_timer_nx = '0;
        case (r_state)
          ST_ARM: begin
            if (flash_req) begin
              w_state_nx = ST_FLASH;
              w_blink_nx = 1'b1;
            end else if (w_ped_grant) begin
              w_state_nx = ST_PED_WALK;
            end else begin
              w_state_nx = ST_MG_SR;
            end
          end
          ST_ARS: begin
            if (flash_req) begin
              w_state_nx = ST_FLASH;
              w_blink_nx = 1'b1;
            end else begin
              w_state_nx = ST_MR_SG;
            end
          end
          ST_MG_SR:    w_state_nx = ST_MY_SR;
          ST_MY_SR:    w_state_nx = ST_ARS;
          ST_MR_SG:    w_state_nx = ST_MR_SY;
          ST_MR_SY:    w_state_nx = ST_ARM;
          ST_PED_WALK: w_state_nx = ST_MG_SR;
          ST_FLASH: begin
            // Leave flash only where the lamps would go dark anyway.
            if (r_blink && !flash_req) begin
              w_state_nx = ST_ARM;
              w_blink_nx = 1'b0;
            end else begin
              w_blink_nx = ~r_blink;
            end
          end
          default:     w_state_nx = ST_ARM;
        endcase
      end else begin
        w_timer_nx = r_timer + CNT_W'(1);
      end
    end
  end

  assign w_chg = (w_state_nx != r_state);

`ifdef TRAFFIC_PED_EN
  // Request set beats the PED_WALK-entry clear; FLASH entry clears unconditionally.
  always_comb begin
    w_ped_nx = r_ped_pending;
    if (w_chg && (w_state_nx == ST_PED_WALK)) w_ped_nx = 1'b0;
    if (ped_req && (r_state != ST_FLASH))     w_ped_nx = 1'b1;
    if (w_chg && (w_state_nx == ST_FLASH))    w_ped_nx = 1'b0;
  end
`else
  logic w_unused_ped;
  assign w_unused_ped = ped_req;
  assign w_ped_nx     = 1'b0;
`endif

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_ARM;
      r_timer       <= '0;
      r_blink       <= 1'b0;
      r_ped_pending <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_timer       <= w_timer_nx;
      r_blink       <= w_blink_nx;
      r_ped_pending <= w_ped_nx;
    end
  end

  assign w_lamps     = decode_lamps(r_state, r_blink);
  assign main_R      = w_lamps.main_l.r;
  assign main_Y      = w_lamps.main_l.y;
  assign main_G      = w_lamps.main_l.g;
  assign side_R      = w_lamps.side_l.r;
  assign side_Y      = w_lamps.side_l.y;
  assign side_G      = w_lamps.side_l.g;
  assign ped_walk    = PED_EN & w_lamps.walk;
  assign ped_pending = PED_EN & r_ped_pending;
  assign phase       = r_state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed scoreboard bench for traffic_phase_ctrl: phase order, durations, lamps, ped and flash.
module tb_traffic_phase_ctrl;

`ifdef TRAFFIC_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  localparam int MAXLEN = 200;

  logic       clk, reset_n, flash_req, ped_req;
  logic       main_R, main_G, main_Y, side_R, side_G, side_Y;
  logic       ped_walk, ped_pending;
  logic [2:0] phase;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] ph;
    int         len;
    logic       blink;
    logic       pp;
    int         ped_at;
    int         fl_on_at;
    int         fl_off_at;
  } exp_t;

  exp_t q[$];

  traffic_phase_ctrl #(
    .CLK_DIV (4), .T_GREEN (6), .T_YELLOW (2), .T_ALLRED (1),
    .T_WALK (4), .T_BLINK (3), .CNT_W (4)
  ) dut (
    .clk_50 (clk), .reset_n (reset_n), .flash_req (flash_req), .ped_req (ped_req),
    .main_R (main_R), .main_G (main_G), .main_Y (main_Y),
    .side_R (side_R), .side_G (side_G), .side_Y (side_Y),
    .ped_walk (ped_walk), .ped_pending (ped_pending), .phase (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {main R,Y,G, side R,Y,G, walk}
  function automatic logic [6:0] lamps_exp(input logic [2:0] ph, input logic b);
    case (ph)
      3'd1:    return 7'b001_100_0;
      3'd2:    return 7'b010_100_0;
      3'd4:    return 7'b100_001_0;
      3'd5:    return 7'b100_010_0;
      3'd6:    return 7'b100_100_1;
      3'd7:    return {1'b0, b, 1'b0, 1'b0, b, 1'b0, 1'b0};
      default: return 7'b100_100_0;
    endcase
  endfunction

  function automatic logic [6:0] lamps_obs();
    return {main_R, main_Y, main_G, side_R, side_Y, side_G, ped_walk};
  endfunction

  function automatic exp_t mk(input logic [2:0] ph, input int len, input logic b,
                              input logic pp, input int ped_at, input int fon, input int foff);
    exp_t e;
    e.ph = ph; e.len = len; e.blink = b; e.pp = pp;
    e.ped_at = ped_at; e.fl_on_at = fon; e.fl_off_at = foff;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the first negedge sample of a phase; returns at the first sample of the next.
  task automatic run_phase(input exp_t e);
    int n;
    n = 0;
    chk($sformatf("phase_%0d", e.ph), 32'(phase), 32'(e.ph));
    chk($sformatf("lamps_%0d", e.ph), 32'(lamps_obs()), 32'(lamps_exp(e.ph, e.blink)));
    chk($sformatf("pending_%0d", e.ph), 32'(ped_pending), 32'(e.pp));
    while ((phase == e.ph) && ((e.ph != 3'd7) || (main_Y == e.blink)) && (n < MAXLEN)) begin
      if (e.ped_at >= 0 && n == e.ped_at) ped_req = 1'b1;
      if (e.ped_at >= 0 && n == e.ped_at + 1) begin
        ped_req = 1'b0;
        chk("ped_latch", 32'(ped_pending), 32'(PED && (e.ph != 3'd7)));
      end
      if (n == e.fl_on_at)  flash_req = 1'b1;
      if (n == e.fl_off_at) flash_req = 1'b0;
      n++;
      @(negedge clk);
    end
    chk($sformatf("len_%0d_b%0d", e.ph, e.blink), 32'(n), 32'(e.len));
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      run_phase(e);
    end
  endtask

  initial begin
    reset_n = 1'b0; flash_req = 1'b0; ped_req = 1'b0;
    #2;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_lamps", 32'(lamps_obs()), 32'(7'b100_100_0));
    chk("rst_pending", 32'(ped_pending), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Normal cycle, ped request in MR_SG, then flash entry/exit.
    q.push_back(mk(3'd0, 4, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd1, 24, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd2, 8, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd3, 4, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd4, 24, 1'b0, 1'b0, 5, -1, -1));
    q.push_back(mk(3'd5, 8, 1'b0, PED, -1, -1, -1));
    q.push_back(mk(3'd0, 4, 1'b0, PED, -1, -1, -1));
    if (PED) q.push_back(mk(3'd6, 16, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd1, 24, 1'b0, 1'b0, -1, 3, -1));
    q.push_back(mk(3'd2, 8, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd3, 4, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd7, 12, 1'b1, 1'b0, 2, -1, -1));
    q.push_back(mk(3'd7, 12, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd7, 12, 1'b1, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd7, 12, 1'b0, 1'b0, -1, -1, 4));
    q.push_back(mk(3'd7, 12, 1'b1, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd0, 4, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd1, 24, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd2, 8, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd3, 4, 1'b0, 1'b0, -1, -1, -1));
    drain();

    // Asynchronous reset in the middle of MR_SG with a request pending.
    chk("mid_phase", 32'(phase), 32'd4);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    chk("mid_pending", 32'(ped_pending), 32'(PED));
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_phase", 32'(phase), 32'd0);
    chk("async_lamps", 32'(lamps_obs()), 32'(7'b100_100_0));
    chk("async_pending", 32'(ped_pending), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    q.push_back(mk(3'd0, 4, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd1, 24, 1'b0, 1'b0, -1, -1, -1));
    drain();

`ifndef TRAFFIC_PED_EN
    // Request held high has no effect without the pedestrian feature.
    ped_req = 1'b1;
    q.push_back(mk(3'd2, 8, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd3, 4, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd4, 24, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd5, 8, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd0, 4, 1'b0, 1'b0, -1, -1, -1));
    q.push_back(mk(3'd1, 24, 1'b0, 1'b0, -1, -1, -1));
    drain();
    ped_req = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
